// File: rtl/interrupt_controller.sv
// Interrupt front end: synchronises irq_in, latches a pending request, owns the I flag,
// and sequences acknowledge, service, RETIE flag restore and the post-return drain gap.
module interrupt_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int GAP_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       irq_in,
  input  logic       sei,
  input  logic       cli,
  input  logic       retie,
  input  logic       int_ack,
  input  logic       c_in,
  input  logic       z_in,
  output logic       interrupt,
  output logic       interrupt_flag,
  output logic       flags_restore,
  output logic       c_shadow,
  output logic       z_shadow,
  output logic       int_pending,
  output logic [7:0] int_count,
  output logic       ack_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_d;
  logic [3:0]             gap_cnt;

  logic synced;
  logic sync_edge;
  logic ack_ok;
  logic pending_next;
  logic flag_next;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign sync_edge = synced & ~synced_d;
  assign ack_ok    = int_ack & interrupt & (state == IDLE);

  // Next pending and I-flag values; the request is computed from these so a
  // synced edge or an sei reaches `interrupt` in a single cycle.
  always_comb begin
    pending_next = int_pending;
    if (EDGE_MODE != 0) begin
      if (sync_edge)
        pending_next = 1'b1;
      else if (ack_ok)
        pending_next = 1'b0;
    end else begin
      pending_next = synced;
    end

    flag_next = interrupt_flag;
    if (ack_ok)
      flag_next = 1'b0;
    else if (cli)
      flag_next = 1'b0;
    else if (retie || sei)
      flag_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sync_q         <= '0;
      synced_d       <= 1'b0;
      gap_cnt        <= 4'd0;
      interrupt      <= 1'b0;
      interrupt_flag <= 1'b0;
      flags_restore  <= 1'b0;
      c_shadow       <= 1'b0;
      z_shadow       <= 1'b0;
      int_pending    <= 1'b0;
      int_count      <= 8'd0;
      ack_err        <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], irq_in};
      synced_d       <= synced;
      int_pending    <= pending_next;
      interrupt_flag <= flag_next;
      flags_restore  <= 1'b0;

      if (int_ack && !interrupt)
        ack_err <= 1'b1;

      case (state)
        IDLE: begin
          if (ack_ok) begin
            c_shadow  <= c_in;
            z_shadow  <= z_in;
            interrupt <= 1'b0;
            if (int_count != 8'hFF)
              int_count <= int_count + 8'd1;
            state <= SERVICE;
          end else begin
            interrupt <= pending_next & flag_next;
          end
        end

        SERVICE: begin
          interrupt <= 1'b0;
          if (retie) begin
            flags_restore <= 1'b1;
            gap_cnt       <= GAP_LOAD;
            state         <= HOLD;
          end
        end

        // The last HOLD cycle already evaluates the request so it can rise
        // exactly GAP_CYCLES cycles after the restore pulse.
        HOLD: begin
          if (gap_cnt == 4'd1) begin
            gap_cnt   <= 4'd0;
            state     <= IDLE;
            interrupt <= pending_next & flag_next;
          end else begin
            gap_cnt   <= gap_cnt - 4'd1;
            interrupt <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller at default parameters; expected values
// are hand-derived cycle by cycle from the intended behaviour.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       irq_in;
  logic       sei;
  logic       cli;
  logic       retie;
  logic       int_ack;
  logic       c_in;
  logic       z_in;
  logic       interrupt;
  logic       interrupt_flag;
  logic       flags_restore;
  logic       c_shadow;
  logic       z_shadow;
  logic       int_pending;
  logic [7:0] int_count;
  logic       ack_err;

  int total = 0;
  int bad   = 0;

  interrupt_controller #(
    .SYNC_STAGES(2),
    .EDGE_MODE  (1),
    .GAP_CYCLES (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .irq_in        (irq_in),
    .sei           (sei),
    .cli           (cli),
    .retie         (retie),
    .int_ack       (int_ack),
    .c_in          (c_in),
    .z_in          (z_in),
    .interrupt     (interrupt),
    .interrupt_flag(interrupt_flag),
    .flags_restore (flags_restore),
    .c_shadow      (c_shadow),
    .z_shadow      (z_shadow),
    .int_pending   (int_pending),
    .int_count     (int_count),
    .ack_err       (ack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Bounded wait for the request; on timeout the caller's check reports it.
  task automatic wait_interrupt();
    for (int i = 0; i < 20; i++) begin
      if (interrupt) break;
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    irq_in  = 1'b0;
    sei     = 1'b0;
    cli     = 1'b0;
    retie   = 1'b0;
    int_ack = 1'b0;
    c_in    = 1'b0;
    z_in    = 1'b0;
    repeat (3) tick();

    check_bit("rst_interrupt", interrupt, 1'b0);
    check_bit("rst_flag", interrupt_flag, 1'b0);
    check_bit("rst_pending", int_pending, 1'b0);
    check_byte("rst_count", int_count, 8'd0);
    check_bit("rst_ack_err", ack_err, 1'b0);

    reset_n = 1'b1;
    tick();
    sei = 1'b1;
    tick();
    sei = 1'b0;
    check_bit("sei_flag", interrupt_flag, 1'b1);
    check_bit("sei_no_int", interrupt, 1'b0);

    // First request: two sync stages plus one registered cycle.
    irq_in = 1'b1;
    tick();
    check_bit("lat1_int", interrupt, 1'b0);
    tick();
    check_bit("lat2_int", interrupt, 1'b0);
    check_bit("lat2_pend", int_pending, 1'b0);
    tick();
    check_bit("lat3_int", interrupt, 1'b1);
    check_bit("lat3_pend", int_pending, 1'b1);

    int_ack = 1'b1;
    c_in    = 1'b1;
    z_in    = 1'b0;
    tick();
    int_ack = 1'b0;
    check_bit("ack_int", interrupt, 1'b0);
    check_bit("ack_flag", interrupt_flag, 1'b0);
    check_byte("ack_count", int_count, 8'd1);
    check_bit("ack_pend", int_pending, 1'b0);
    check_bit("ack_no_err", ack_err, 1'b0);

    // New edge during service latches pending but raises nothing.
    c_in   = 1'b0;
    z_in   = 1'b1;
    irq_in = 1'b0;
    repeat (3) tick();
    irq_in = 1'b1;
    repeat (3) tick();
    check_bit("svc_pend", int_pending, 1'b1);
    check_bit("svc_int", interrupt, 1'b0);

    retie = 1'b1;
    tick();
    retie = 1'b0;
    check_bit("ret_restore", flags_restore, 1'b1);
    check_bit("ret_c_shadow", c_shadow, 1'b1);
    check_bit("ret_z_shadow", z_shadow, 1'b0);
    check_bit("ret_flag", interrupt_flag, 1'b1);
    check_bit("gap0_int", interrupt, 1'b0);
    tick();
    check_bit("ret_restore_once", flags_restore, 1'b0);
    check_bit("gap1_int", interrupt, 1'b0);
    tick();
    check_bit("gap2_int", interrupt, 1'b0);
    tick();
    check_bit("gap_end_int", interrupt, 1'b1);

    // cli drops the request but keeps pending; sei brings it back.
    cli = 1'b1;
    tick();
    cli = 1'b0;
    check_bit("cli_int", interrupt, 1'b0);
    check_bit("cli_pend", int_pending, 1'b1);
    check_bit("cli_flag", interrupt_flag, 1'b0);
    sei = 1'b1;
    tick();
    sei = 1'b0;
    check_bit("resei_int", interrupt, 1'b1);

    // Synced edge arrives in the same cycle as the accepted ack.
    irq_in = 1'b0;
    repeat (3) tick();
    irq_in = 1'b1;
    tick();
    tick();
    check_bit("pre_coinc_int", interrupt, 1'b1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_bit("coinc_pend", int_pending, 1'b1);
    check_byte("coinc_count", int_count, 8'd2);
    check_bit("coinc_int", interrupt, 1'b0);
    check_bit("coinc_flag", interrupt_flag, 1'b0);

    retie = 1'b1;
    tick();
    retie = 1'b0;
    check_bit("ret2_restore", flags_restore, 1'b1);
    check_bit("ret2_c_shadow", c_shadow, 1'b0);
    check_bit("ret2_z_shadow", z_shadow, 1'b1);
    tick();
    tick();
    check_bit("gap2b_int", interrupt, 1'b0);
    tick();
    check_bit("second_req_int", interrupt, 1'b1);

    int_ack = 1'b1;
    tick();
    check_byte("third_count", int_count, 8'd3);
    tick();
    int_ack = 1'b0;
    check_bit("spurious_err", ack_err, 1'b1);
    check_byte("spurious_count", int_count, 8'd3);
    tick();
    check_bit("err_sticky", ack_err, 1'b1);

    retie = 1'b1;
    tick();
    retie = 1'b0;
    repeat (3) tick();
    check_bit("no_pend_int", interrupt, 1'b0);

    sei = 1'b1;
    cli = 1'b1;
    tick();
    sei = 1'b0;
    cli = 1'b0;
    check_bit("sei_cli_flag", interrupt_flag, 1'b0);

    retie = 1'b1;
    tick();
    retie = 1'b0;
    check_bit("idle_retie_flag", interrupt_flag, 1'b1);
    check_bit("idle_retie_no_restore", flags_restore, 1'b0);

    // Saturation: service enough further interrupts to pass 255.
    for (int n = 0; n < 256; n++) begin
      irq_in = 1'b0;
      repeat (3) tick();
      irq_in = 1'b1;
      wait_interrupt();
      check_bit("loop_int", interrupt, 1'b1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      retie = 1'b1;
      tick();
      retie = 1'b0;
    end
    check_byte("sat_count", int_count, 8'd255);
    check_bit("sat_err_held", ack_err, 1'b1);

    // Reset during service is asynchronous and abandons the restore.
    irq_in = 1'b0;
    repeat (3) tick();
    irq_in = 1'b1;
    wait_interrupt();
    check_bit("final_int", interrupt, 1'b1);
    c_in    = 1'b1;
    z_in    = 1'b1;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_bit("final_c_shadow", c_shadow, 1'b1);
    irq_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("arst_c_shadow", c_shadow, 1'b0);
    check_bit("arst_z_shadow", z_shadow, 1'b0);
    check_byte("arst_count", int_count, 8'd0);
    check_bit("arst_err", ack_err, 1'b0);
    check_bit("arst_flag", interrupt_flag, 1'b0);
    check_bit("arst_pend", int_pending, 1'b0);
    tick();
    reset_n = 1'b1;
    retie   = 1'b1;
    tick();
    retie = 1'b0;
    check_bit("post_rst_no_restore", flags_restore, 1'b0);
    check_bit("post_rst_flag", interrupt_flag, 1'b1);
    check_bit("post_rst_int", interrupt, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
